// File: rtl/mips24_pkg.sv
// mips24_pkg
// Shared definitions for the 24-bit multicycle core front end:
//   - default data/address widths
//   - instruction register field positions
//   - next-PC source encodings driven by pc_control
//   - fetch FSM state enumeration
// No ports (package).
package mips24_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 24;

  // IR field positions
  localparam int OPC_HI  = 23;
  localparam int OPC_LO  = 19;
  localparam int COND_HI = 18;
  localparam int COND_LO = 17;
  localparam int RD_HI   = 16;
  localparam int RD_LO   = 14;
  localparam int RS1_HI  = 13;
  localparam int RS1_LO  = 11;
  localparam int RS2_HI  = 10;
  localparam int RS2_LO  = 8;
  localparam int IMM_HI  = 10;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = IMM_HI - IMM_LO + 1;
  localparam int OFF_HI  = 16;
  localparam int OFF_LO  = 0;
  localparam int OFF_W   = OFF_HI - OFF_LO + 1;

  // Next-PC source encodings
  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_RET = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
// Circular return-address stack used by the fetch unit when FETCH_RAS_EN is
// defined. Pushing onto a full stack overwrites the oldest entry. A push and a
// pop in the same cycle pop the current top first and then push, so the new
// value replaces the old top. Popping an empty stack leaves it unchanged.
// Ports:
//   i_clk    core clock
//   i_reset  synchronous, active-low; empties the stack
//   i_push   write i_data as the new top
//   i_pop    discard the current top
//   i_data   value to push
//   o_top    current top entry (meaningless when o_empty)
//   o_empty  no valid entries
//   o_full   DEPTH valid entries
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // r_sp is the slot the next push writes; the top lives one slot below it.
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_base;
  logic [PTR_W-1:0] w_base_inc;
  logic [CNT_W-1:0] w_base_count;
  logic             w_do_pop;

  // A pop first rewinds the pointer; a same-cycle push then works from that
  // rewound position, which makes push+pop a replace-top.
  always_comb begin
    w_top_idx    = (r_sp == '0) ? PTR_W'(DEPTH - 1) : r_sp - PTR_W'(1);
    w_do_pop     = i_pop && !o_empty;
    w_base       = w_do_pop ? w_top_idx : r_sp;
    w_base_count = w_do_pop ? r_count - CNT_W'(1) : r_count;
    w_base_inc   = (w_base == PTR_W'(DEPTH - 1)) ? '0 : w_base + PTR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_sp    <= w_base_inc;
      r_count <= (w_base_count == CNT_W'(DEPTH)) ? w_base_count
                                                 : w_base_count + CNT_W'(1);
    end else if (w_do_pop) begin
      r_sp    <= w_base;
      r_count <= w_base_count;
    end
  end

  // Storage needs no reset: r_count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_reset && i_push) begin
      r_mem[w_base] <= i_data;
    end
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
// Fetch stage of the 24-bit multicycle core. Owns the PC and the instruction
// register, drives instruction_memory, decodes IR fields combinationally and
// applies the next-PC selection when control_unit commits an instruction.
// Optional feature macro: FETCH_RAS_EN (internal return stack replaces
// i_ret_addr for returns and adds the i_ras_push port).
// Ports:
//   i_clk          core clock
//   i_reset        synchronous, active-low
//   i_fetch_req    start a fetch at the current PC (IDLE/HOLD only)
//   i_pc_we        commit next PC (IDLE/HOLD only, otherwise protocol error)
//   i_pc_src       00 PC+1, 01 PC+1+sext(imm11), 10 zext(off17), 11 return
//   i_ret_addr     return target for pc_src=11 (ignored with FETCH_RAS_EN)
//   i_ras_push     push PC+1 with the commit (FETCH_RAS_EN only)
//   o_imem_addr    instruction address, always equal to the PC
//   o_imem_rd      read strobe, high for the single FETCH cycle
//   i_imem_data    memory data, valid one cycle after the strobe
//   o_pc           current PC
//   o_instr        IR contents
//   o_instr_valid  one-cycle pulse after the IR is loaded
//   o_opcode/o_cond/o_rd/o_rs1/o_rs2  IR fields
//   o_imm          sign-extended IR[10:0]
//   o_fetch_err    sticky protocol error, cleared only by reset
module fetch_decode_unit
  import mips24_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch_req,
  input  logic              i_pc_we,
  input  logic [1:0]        i_pc_src,
  input  logic [ADDR_W-1:0] i_ret_addr,
`ifdef FETCH_RAS_EN
  input  logic              i_ras_push,
`endif
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_rd,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  output logic [4:0]        o_opcode,
  output logic [1:0]        o_cond,
  output logic [2:0]        o_rd,
  output logic [2:0]        o_rs1,
  output logic [2:0]        o_rs2,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_fetch_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic              w_imem_rd;
  logic              w_load_ir;
  logic              w_pc_ok;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_valid;
  logic              r_err;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_branch;
  logic [ADDR_W-1:0] w_pc_jump;
  logic [ADDR_W-1:0] w_ret_target;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_ret_err;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC commits are only legal while no fetch is in flight (IDLE/HOLD);
  // fetch requests arriving mid-fetch are simply dropped.
  always_comb begin
    w_state_next = r_state;
    w_imem_rd    = 1'b0;
    w_load_ir    = 1'b0;
    w_pc_ok      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_ok = 1'b1;
        if (i_fetch_req) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_rd    = 1'b1;
        w_state_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_load_ir    = 1'b1;
        w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_pc_ok = 1'b1;
        if (i_fetch_req) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Next-PC candidates; all arithmetic wraps at ADDR_W bits.
  always_comb begin
    w_pc_inc    = r_pc + ADDR_W'(1);
    w_pc_branch = w_pc_inc + {{(ADDR_W-IMM_W){r_ir[IMM_HI]}}, r_ir[IMM_HI:IMM_LO]};
    w_pc_jump   = {{(ADDR_W-OFF_W){1'b0}}, r_ir[OFF_HI:OFF_LO]};
    case (i_pc_src)
      PC_SRC_INC: w_pc_next = w_pc_inc;
      PC_SRC_BR:  w_pc_next = w_pc_branch;
      PC_SRC_JMP: w_pc_next = w_pc_jump;
      default:    w_pc_next = w_ret_target;
    endcase
  end

`ifdef FETCH_RAS_EN
  logic              w_ras_push;
  logic              w_ras_pop;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_unused_ras;

  assign w_ras_pop  = i_pc_we && w_pc_ok && (i_pc_src == PC_SRC_RET);
  assign w_ras_push = i_pc_we && w_pc_ok && i_ras_push;

  ret_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  // An underflowing return restarts from the reset vector and flags the error.
  assign w_ret_target = w_ras_empty ? RESET_PC : w_ras_top;
  assign w_ret_err    = w_ras_pop && w_ras_empty;
  assign w_unused_ras = ^{i_ret_addr, w_ras_full};
`else
  logic w_unused_cfg;

  assign w_ret_target = i_ret_addr;
  assign w_ret_err    = 1'b0;
  assign w_unused_cfg = (RAS_DEPTH > 0);
`endif

  // PC, IR, valid pulse and sticky error. Reset discards any in-flight read
  // because the IR load is gated by the LATCH state, which reset leaves.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_load_ir;
      if (w_load_ir) r_ir <= i_imem_data;
      if (i_pc_we && w_pc_ok) r_pc <= w_pc_next;
      if ((i_pc_we && !w_pc_ok) || w_ret_err) r_err <= 1'b1;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_imem_rd     = w_imem_rd;
  assign o_pc          = r_pc;
  assign o_instr       = r_ir;
  assign o_instr_valid = r_valid;
  assign o_opcode      = r_ir[OPC_HI:OPC_LO];
  assign o_cond        = r_ir[COND_HI:COND_LO];
  assign o_rd          = r_ir[RD_HI:RD_LO];
  assign o_rs1         = r_ir[RS1_HI:RS1_LO];
  assign o_rs2         = r_ir[RS2_HI:RS2_LO];
  assign o_imm         = {{(DATA_W-IMM_W){r_ir[IMM_HI]}}, r_ir[IMM_HI:IMM_LO]};
  assign o_fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit
// Self-checking bench for fetch_decode_unit. A behavioural model (PC, IR,
// error flag and a queue-based return stack) tracks the expected state and
// a synchronous instruction memory answers read strobes one cycle later.
// Define FETCH_RAS_EN to exercise the return-stack build.
module tb_fetch_decode_unit;

  localparam logic [23:0] RESET_PC  = 24'h000000;
  localparam int          RAS_DEPTH = 4;

  logic        clk;
  logic        resetN;
  logic        fetchReq;
  logic        pcWe;
  logic [1:0]  pcSrc;
  logic [23:0] retAddr;
  logic        rasPush;
  logic [23:0] imemAddr;
  logic        imemRd;
  logic [23:0] imemData;
  logic [23:0] pc;
  logic [23:0] instr;
  logic        instrValid;
  logic [4:0]  opcode;
  logic [1:0]  cond;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [23:0] imm;
  logic        fetchErr;

  int vectors    = 0;
  int miscompares = 0;

  logic [23:0] mPc;
  logic [23:0] mIr;
  logic        mErr;
  logic [23:0] mStack [$];
  logic [23:0] imem [logic [23:0]];

  fetch_decode_unit #(
    .DATA_W    (24),
    .ADDR_W    (24),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_reset       (resetN),
    .i_fetch_req   (fetchReq),
    .i_pc_we       (pcWe),
    .i_pc_src      (pcSrc),
    .i_ret_addr    (retAddr),
`ifdef FETCH_RAS_EN
    .i_ras_push    (rasPush),
`endif
    .o_imem_addr   (imemAddr),
    .o_imem_rd     (imemRd),
    .i_imem_data   (imemData),
    .o_pc          (pc),
    .o_instr       (instr),
    .o_instr_valid (instrValid),
    .o_opcode      (opcode),
    .o_cond        (cond),
    .o_rd          (rd),
    .o_rs1         (rs1),
    .o_rs2         (rs2),
    .o_imm         (imm),
    .o_fetch_err   (fetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten addresses return a fixed scramble of the address.
  function automatic logic [23:0] memWord(input logic [23:0] a);
    if (imem.exists(a)) return imem[a];
    return (a * 24'h5BD1E9) ^ 24'hA5C3E7;
  endfunction

  always @(posedge clk) begin
    if (imemRd === 1'b1) imemData <= memWord(imemAddr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs are held across exactly one rising edge, then outputs settle.
  task automatic applyStimulus(input bit fetch, input bit we, input logic [1:0] src,
                               input logic [23:0] ret, input bit push);
    fetchReq = fetch;
    pcWe     = we;
    pcSrc    = src;
    retAddr  = ret;
    rasPush  = push;
    @(posedge clk);
    #1;
    fetchReq = 1'b0;
    pcWe     = 1'b0;
    rasPush  = 1'b0;
  endtask

  // Expected effect of an accepted PC commit, from the next-PC rules.
  task automatic modelPcWe(input logic [1:0] src, input logic [23:0] ret, input bit push);
    logic [23:0] inc;
    logic [23:0] tgt;
    inc = mPc + 24'd1;
    case (src)
      2'b00: tgt = inc;
      2'b01: tgt = inc + {{13{mIr[10]}}, mIr[10:0]};
      2'b10: tgt = {7'b0, mIr[16:0]};
      default: begin
`ifdef FETCH_RAS_EN
        if (mStack.size() == 0) begin
          tgt  = RESET_PC;
          mErr = 1'b1;
        end else begin
          tgt = mStack.pop_back();
        end
`else
        tgt = ret;
`endif
      end
    endcase
`ifdef FETCH_RAS_EN
    if (push) begin
      mStack.push_back(inc);
      if (mStack.size() > RAS_DEPTH) void'(mStack.pop_front());
    end
`else
    if (push) tgt = tgt;
`endif
    mPc = tgt;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ":pc"},     pc,       mPc);
    checkOutput({tag, ":addr"},   imemAddr, mPc);
    checkOutput({tag, ":instr"},  instr,    mIr);
    checkOutput({tag, ":opcode"}, opcode,   mIr[23:19]);
    checkOutput({tag, ":cond"},   cond,     mIr[18:17]);
    checkOutput({tag, ":rd"},     rd,       mIr[16:14]);
    checkOutput({tag, ":rs1"},    rs1,      mIr[13:11]);
    checkOutput({tag, ":rs2"},    rs2,      mIr[10:8]);
    checkOutput({tag, ":imm"},    imm,      {{13{mIr[10]}}, mIr[10:0]});
    checkOutput({tag, ":err"},    fetchErr, mErr);
  endtask

  // Full fetch from IDLE/HOLD, optionally with a same-cycle PC commit.
  task automatic doFetch(input bit we, input logic [1:0] src, input bit push);
    logic [23:0] ret;
    ret = 24'($urandom);
    applyStimulus(1'b1, we, src, ret, push);
    if (we) modelPcWe(src, ret, push);
    checkOutput("fetch:rd",    imemRd,     1);
    checkOutput("fetch:addr",  imemAddr,   mPc);
    checkOutput("fetch:valid", instrValid, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("latch:rd",    imemRd,     0);
    checkOutput("latch:valid", instrValid, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    mIr = memWord(mPc);
    checkOutput("load:valid", instrValid, 1);
    checkModel("load");
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("hold:valid", instrValid, 0);
    checkOutput("hold:rd",    imemRd,     0);
  endtask

  task automatic commitPc(input string tag, input logic [1:0] src, input bit push);
    logic [23:0] ret;
    ret = 24'($urandom);
    applyStimulus(1'b0, 1'b1, src, ret, push);
    modelPcWe(src, ret, push);
    checkModel(tag);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("reset:pc",    pc,         RESET_PC);
    checkOutput("reset:instr", instr,      0);
    checkOutput("reset:valid", instrValid, 0);
    checkOutput("reset:rd",    imemRd,     0);
    checkOutput("reset:err",   fetchErr,   0);
    resetN = 1'b1;
    mPc = RESET_PC;
    mIr = 24'h0;
    mErr = 1'b0;
    mStack.delete();
  endtask

  initial begin
    fetchReq = 1'b0;
    pcWe     = 1'b0;
    pcSrc    = 2'b00;
    retAddr  = 24'h0;
    rasPush  = 1'b0;
    resetN   = 1'b0;
    $display("[TB] start");

    // Reset, then idle: no read strobe without a request.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("idle:rd", imemRd, 0);

    // First fetch at PC 0 with a known word and its decoded fields.
    imem[24'h000000] = 24'h8A4C2F;
    doFetch(1'b0, 2'b00, 1'b0);
    checkOutput("dec:opcode", opcode, 5'h11);
    checkOutput("dec:cond",   cond,   2'd1);
    checkOutput("dec:rd",     rd,     3'd1);
    checkOutput("dec:rs1",    rs1,    3'd1);
    checkOutput("dec:rs2",    rs2,    3'd4);
    checkOutput("dec:imm",    imm,    24'hFFFC2F);

    // Walk to PC 0x10 and apply both branch offsets from there.
    imem[24'h000001] = 24'h100010;
    imem[24'h000010] = 24'h1807FE;
    commitPc("inc", 2'b00, 1'b0);
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("jmp10", 2'b10, 1'b0);
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("brneg", 2'b01, 1'b0);
    checkOutput("brneg:const", pc, 24'h00000F);
    imem[24'h00000F] = 24'h100010;
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("jmp10b", 2'b10, 1'b0);
    imem[24'h000010] = 24'h180005;
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("brpos", 2'b01, 1'b0);
    checkOutput("brpos:const", pc, 24'h000016);

    // Wrap: branch back from 0 to all-ones, then PC+1 together with a
    // fetch request so the fetch must use the wrapped address 0.
    imem[24'h000016] = 24'h100000;
    imem[24'h000000] = 24'h1807FE;
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("jmp0", 2'b10, 1'b0);
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("wrapdn", 2'b01, 1'b0);
    checkOutput("wrapdn:const", pc, 24'hFFFFFF);
    doFetch(1'b1, 2'b00, 1'b0);
    checkOutput("wrapup:const", pc, 24'h000000);

    // Randomised fetch/commit traffic.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] src;
      bit         combine;
      combine = ($urandom_range(0, 3) == 0);
      if (!combine) imem[mPc] = 24'($urandom);
      doFetch(combine, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      src = 2'($urandom_range(0, 3));
      commitPc("rand", src, 1'($urandom_range(0, 1)));
    end

    // Protocol error: commits during FETCH and LATCH are refused and flag
    // the sticky error; fetch requests there are dropped silently.
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b00, 24'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 24'h0, 1'b0);
    mErr = 1'b1;
    checkOutput("errfetch:pc",  pc,       mPc);
    checkOutput("errfetch:err", fetchErr, 1);
    applyStimulus(1'b1, 1'b1, 2'b10, 24'h0, 1'b0);
    mIr = memWord(mPc);
    checkOutput("errlatch:valid", instrValid, 1);
    checkOutput("errlatch:rd",    imemRd,     0);
    checkModel("errlatch");
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("errhold:rd", imemRd, 0);
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("errsticky", 2'b00, 1'b0);

    // Reset while in LATCH: the read is discarded and no valid pulse follows.
    applyStimulus(1'b1, 1'b0, 2'b00, 24'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    resetN = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    resetN = 1'b1;
    mPc = RESET_PC;
    mIr = 24'h0;
    mErr = 1'b0;
    mStack.delete();
    checkOutput("rstlatch:valid", instrValid, 0);
    checkModel("rstlatch");
    applyStimulus(1'b0, 1'b0, 2'b00, 24'h0, 1'b0);
    checkOutput("rstidle:valid", instrValid, 0);
    checkOutput("rstidle:rd",    imemRd,     0);

`ifdef FETCH_RAS_EN
    // Five calls overflow a four-deep stack; four returns unwind the newest
    // entries and a fifth underflows to the reset vector.
    doReset();
    imem[24'h000000] = 24'h100010;
    for (int k = 1; k <= 5; k++) imem[24'(k * 16)] = 24'h100000 | 24'((k + 1) * 16);
    doFetch(1'b0, 2'b00, 1'b0);
    commitPc("rasgo", 2'b10, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      doFetch(1'b0, 2'b00, 1'b0);
      commitPc("rascall", 2'b10, 1'b1);
    end
    begin
      logic [23:0] expRet [4];
      expRet = '{24'h000051, 24'h000041, 24'h000031, 24'h000021};
      for (int k = 0; k < 4; k++) begin
        commitPc("rasret", 2'b11, 1'b0);
        checkOutput("rasret:const", pc, expRet[k]);
      end
    end
    commitPc("rasunder", 2'b11, 1'b0);
    checkOutput("rasunder:pc",  pc,       RESET_PC);
    checkOutput("rasunder:err", fetchErr, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
